// File: rtl/uart_monitor_pkg.sv
// Shared types and helpers for the UART line monitor: receiver state encoding
// and the clocks-per-bit derivation used to time bit sampling.
package uart_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Rounded division so non-integer ratios land on the nearest whole clock count.
  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return (clk_freq_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive buffer: valid/ready head, occupancy count, and a one-cycle
// overflow pulse when a byte is offered while full with nothing leaving.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  output logic                       overflow_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop;
  logic             full;
  logic             accept;

  assign valid_o    = (count_q != '0);
  assign data_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    pop        = valid_o && ready_i;
    accept     = push_i && (!full || pop);
    overflow_d = push_i && full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/uart_tx_monitor.sv
// Passive 8N1 receiver watching the SoC UART transmit pad; framed bytes are
// buffered for a valid/ready consumer and bad stop bits raise a single pulse.
module uart_tx_monitor
  import uart_monitor_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            ref_clk,
  input  logic                            pad_reset,
  input  logic                            rx_i,
  output logic [7:0]                      data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            frame_err_o,
  output logic                            overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);

  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push;

  assign frame_err_o = frame_err_q;

  // Every sample is taken when the countdown expires; the first countdown is a
  // half bit so all later samples land near bit centres.
  always_comb begin
    rx_meta_d   = rx_i;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d   = DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[bit_idx_q] = rx_sync_q;
          cnt_d              = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_sync_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (pad_reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk        (ref_clk),
    .reset      (pad_reset),
    .push_i     (push),
    .push_data_i(shift_q),
    .overflow_o (overflow_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o)
  );

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Scoreboard bench for uart_tx_monitor: frames are serialised at a reduced baud
// ratio, expected bytes and pulses are queued at send time and checked by a monitor.
module tb_uart_tx_monitor;

  localparam int CLK_FREQ_HZ = 1_600_000;
  localparam int BAUD        = 100_000;
  localparam int FIFO_DEPTH  = 8;
  localparam int CPB         = 16;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  // Start edge crosses two synchroniser flops and one edge-detect cycle, then
  // a half bit plus nine full bits reach the stop-bit sample.
  localparam int STOP_SAMPLE = 3 + CPB / 2 + 9 * CPB;

  logic             ref_clk   = 1'b0;
  logic             pad_reset = 1'b1;
  logic             rx_i      = 1'b1;
  logic             ready_i   = 1'b0;
  logic [7:0]       data_o;
  logic             valid_o;
  logic             frame_err_o;
  logic             overflow_o;
  logic [CNT_W-1:0] count_o;

  int         checks          = 0;
  int         failures        = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr        = 0;
  int         obs_ferr        = 0;
  int         exp_ovf         = 0;
  int         obs_ovf         = 0;
  int         ready_mode      = 0;
  int         cyc             = 0;
  int         frame_start_cyc = 0;
  int         last_pop_cyc    = -1;

  uart_tx_monitor #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .ref_clk    (ref_clk),
    .pad_reset  (pad_reset),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .count_o    (count_o)
  );

  always #5 ref_clk = ~ref_clk;

  always @(posedge ref_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge ref_clk);
    rx_i = v;
    repeat (CPB - 1) @(negedge ref_clk);
  endtask

  // The model decides at send time what the frame must produce.
  task automatic applyStimulus(input logic [7:0] b, input bit good_stop, input bit coincide_pop);
    if (!good_stop) exp_ferr++;
    else if (exp_q.size() < FIFO_DEPTH || coincide_pop) exp_q.push_back(b);
    else exp_ovf++;
    @(negedge ref_clk);
    rx_i = 1'b0;
    frame_start_cyc = cyc;
    repeat (CPB - 1) @(negedge ref_clk);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good_stop);
    if (!good_stop) repeat (3) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 * CPB && exp_q.size() != 0; i++) @(negedge ref_clk);
    checkOutput({name, "_left_undelivered"}, exp_q.size(), 0);
    repeat (4) @(negedge ref_clk);
  endtask

  task automatic check_phase(input string name);
    @(negedge ref_clk);
    #2;
    checkOutput({name, "_frame_err_pulses"}, obs_ferr, exp_ferr);
    checkOutput({name, "_overflow_pulses"}, obs_ovf, exp_ovf);
    checkOutput({name, "_count"}, int'(count_o), exp_q.size());
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput({name, "_count"}, int'(count_o), 0);
    checkOutput({name, "_valid"}, int'(valid_o), 0);
    checkOutput({name, "_data"}, int'(data_o), 0);
    checkOutput({name, "_frame_err"}, int'(frame_err_o), 0);
    checkOutput({name, "_overflow"}, int'(overflow_o), 0);
  endtask

  initial begin
    forever begin
      @(negedge ref_clk);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: one sample per cycle, after drivers settle and before the next rising edge.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge ref_clk);
      #2;
      if (frame_err_o) obs_ferr++;
      if (overflow_o) obs_ovf++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte: got 0x%02h while nothing was expected", data_o);
        end else begin
          exp_b = exp_q.pop_front();
          checkOutput("fifo_data", int'(data_o), int'(exp_b));
          last_pop_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #600_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int latency;
    logic [7:0] abandoned;

    repeat (3) @(negedge ref_clk);
    #2;
    check_reset_outputs("por");
    @(negedge ref_clk);
    pad_reset = 1'b0;
    repeat (2 * CPB) @(negedge ref_clk);

    $display("[TB] single byte 0x55 with consumer ready");
    ready_mode = 1;
    applyStimulus(8'h55, 1'b1, 1'b0);
    drain("b55");
    latency = last_pop_cyc - frame_start_cyc;
    checks++;
    if (latency < 9 * CPB + CPB / 2 || latency > 9 * CPB + CPB / 2 + 4) begin
      failures++;
      $display("[TB] FAIL b55_latency: got %0d cycles expected %0d..%0d", latency,
               9 * CPB + CPB / 2, 9 * CPB + CPB / 2 + 4);
    end
    check_phase("b55");

    $display("[TB] short low glitch then 0xA3");
    @(negedge ref_clk);
    rx_i = 1'b0;
    repeat (3) @(negedge ref_clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge ref_clk);
    check_phase("glitch");
    applyStimulus(8'hA3, 1'b1, 1'b0);
    drain("bA3");
    check_phase("bA3");

    $display("[TB] break frame 0x3C then 0x81");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    applyStimulus(8'h81, 1'b1, 1'b0);
    drain("b81");
    check_phase("break");

    $display("[TB] fill buffer with consumer stalled");
    ready_mode = 0;
    for (int i = 0; i <= FIFO_DEPTH; i++) applyStimulus(8'(i), 1'b1, 1'b0);
    check_phase("fill");

    $display("[TB] push into full buffer coinciding with a pop");
    fork
      applyStimulus(8'hC5, 1'b1, 1'b1);
      begin
        repeat (STOP_SAMPLE) @(negedge ref_clk);
        ready_mode = 1;
        @(negedge ref_clk);
        ready_mode = 0;
      end
    join
    check_phase("coincide");
    ready_mode = 1;
    drain("coincide");
    check_phase("coincide_drained");

    $display("[TB] reset during data bit 4");
    abandoned = 8'h5A;
    @(negedge ref_clk);
    rx_i = 1'b0;
    repeat (CPB - 1) @(negedge ref_clk);
    for (int i = 0; i < 4; i++) send_bit(abandoned[i]);
    @(negedge ref_clk);
    rx_i = abandoned[4];
    repeat (CPB / 2) @(negedge ref_clk);
    pad_reset = 1'b1;
    rx_i      = 1'b1;
    @(negedge ref_clk);
    pad_reset = 1'b0;
    #2;
    check_reset_outputs("midframe_reset");
    repeat (3 * CPB) @(negedge ref_clk);
    applyStimulus(8'hF0, 1'b1, 1'b0);
    drain("bF0");
    check_phase("after_reset");

    $display("[TB] random frames with random consumer stalls");
    ready_mode = 2;
    for (int n = 0; n < 6; n++) begin
      applyStimulus(8'($urandom), $urandom_range(0, 4) != 0, 1'b0);
      repeat ($urandom_range(0, CPB)) @(negedge ref_clk);
    end
    ready_mode = 1;
    drain("random");
    check_phase("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
